// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pool scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default pixel width, scheduler state enum, pair packing, result-count helper.
package pool_pkg;

  localparam int DW        = 22;
  localparam int IMG_W_DEF = 24;
  localparam int IMG_H_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    EVEN_ROW,
    ODD_ROW,
    DRAIN,
    FIN
  } state_t;

  // Left pixel (even column) lands in the MSBs.
  function automatic logic [2*DW-1:0] pack_pair(input logic [DW-1:0] left,
                                                input logic [DW-1:0] right);
    return {left, right};
  endfunction

  // One compare result per 2x2 window.
  function automatic int res_count(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

  localparam int RES_CNT_DEF = res_count(IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/pool_sched_if.sv
// Pixel stream and compare-unit signals of the pool scheduler.
// Latency: n/a (wiring only).
// Backpressure: pix_valid/pix_ready handshake; cmp_* are strobes with no backpressure.
// Modports: master = upstream source + compare unit side, slave = scheduler side.
interface pool_sched_if #(
  parameter int DW = pool_pkg::DW
);
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          cmp_valid;
  logic [2*DW-1:0] cmp_x_m_1;
  logic [2*DW-1:0] cmp_x_m_2;
  logic          cmp_res_valid;

  modport master (
    output pix_valid, pix_data, cmp_res_valid,
    input  pix_ready, cmp_valid, cmp_x_m_1, cmp_x_m_2
  );

  modport slave (
    input  pix_valid, pix_data, cmp_res_valid,
    output pix_ready, cmp_valid, cmp_x_m_1, cmp_x_m_2
  );
endinterface

// File: rtl/pool_linebuf.sv
// One-row buffer of column pairs for the pool scheduler (simple dual port).
// Latency: write takes effect at the clock edge; read data registered, valid 1 cycle after rd_en.
// Backpressure: none; rd_dat holds its value while rd_en is low.
// Ports: clk/rstn, write port (wr_en, wr_addr, wr_dat), read port (rd_en, rd_addr, rd_dat).
module pool_linebuf
  import pool_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int WIDTH = 2 * DW,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/pool_sched.sv
// Frame scheduler feeding 2x2 windows to the max-pool compare unit and counting its results.
// Latency: compare request 1 cycle after the edge accepting the odd-row, odd-column pixel.
// Backpressure: pix_ready high only while streaming rows; upstream stalls freeze col/row/hold.
// Ports: clk, rstn, start; io (pool_sched_if.slave: pixel stream, compare request, result strobe);
//        busy, done, out_cnt[15:0]; err only when POOL_SCHED_TIMEOUT_EN is defined (drain watchdog).
module pool_sched
  import pool_pkg::*;
#(
  parameter int DW          = pool_pkg::DW,
  parameter int IMG_W       = 24,
  parameter int IMG_H       = 24,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  pool_sched_if.slave io,
  output logic        busy,
  output logic        done,
  output logic [15:0] out_cnt
`ifdef POOL_SCHED_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  localparam int PW       = 2 * DW;
  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int NRES     = res_count(IMG_W, IMG_H);
  localparam int OCW      = $clog2(NRES + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [DW-1:0]   hold_q;
  logic [OCW-1:0]  cnt_q;
  logic            cmp_vld_q;
  logic [PW-1:0]   x2_q;
  logic            tmo;

  logic            acc, last_col, odd_col, last_pair, start_acc;
  logic            lb_wr, lb_rd;
  logic [AW-1:0]   lb_addr;
  logic [PW-1:0]   lb_rd_dat;

  assign acc       = io.pix_valid && io.pix_ready;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign odd_col   = col_q[0];
  assign last_pair = (row_q == RW'(IMG_H - 2));
  assign start_acc = (state_q == IDLE) && start;
  assign lb_addr   = AW'(col_q >> 1);

  // Each pair index is written once in the even row and read once in the odd row,
  // so read and write never collide on the same entry.
  assign lb_wr = acc && (state_q == EVEN_ROW) && odd_col;
  assign lb_rd = acc && (state_q == ODD_ROW) && odd_col;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io.pix_ready = 1'b0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = EVEN_ROW;
      EVEN_ROW: begin
        io.pix_ready = 1'b1;
        if (acc && last_col) state_d = ODD_ROW;
      end
      ODD_ROW:  begin
        io.pix_ready = 1'b1;
        if (acc && last_col) state_d = last_pair ? DRAIN : EVEN_ROW;
      end
      DRAIN:    if ((cnt_q == OCW'(NRES)) || tmo) state_d = FIN;
      FIN:      begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q     <= '0;
      row_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      cmp_vld_q <= 1'b0;
      x2_q      <= '0;
    end else begin
      cmp_vld_q <= 1'b0;
      if (start_acc) begin
        col_q <= '0;
        row_q <= '0;
        cnt_q <= '0;
      end else begin
        // Results may arrive while the odd row is still streaming.
        if (busy && io.cmp_res_valid) cnt_q <= cnt_q + OCW'(1);
        if (acc) begin
          col_q <= last_col ? '0 : col_q + CW'(1);
          if (!odd_col) hold_q <= io.pix_data;
          if (lb_rd) begin
            cmp_vld_q <= 1'b1;
            x2_q      <= {hold_q, io.pix_data};
          end
          if ((state_q == ODD_ROW) && last_col) row_q <= row_q + RW'(2);
        end
      end
    end
  end

  pool_linebuf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PW),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_dat  ({hold_q, io.pix_data}),
    .rd_en   (lb_rd),
    .rd_addr (lb_addr),
    .rd_dat  (lb_rd_dat)
  );

  assign io.cmp_valid = cmp_vld_q;
  assign io.cmp_x_m_1 = lb_rd_dat;
  assign io.cmp_x_m_2 = x2_q;
  assign out_cnt      = 16'(cnt_q);

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;

  // Watchdog counts quiet DRAIN cycles; any result reloads it.
  assign tmo = (state_q == DRAIN) && !io.cmp_res_valid &&
               (cnt_q != OCW'(NRES)) && (wd_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= ((state_q == DRAIN) && !io.cmp_res_valid) ? wd_q + TW'(1) : '0;
      if (start_acc) err_q <= 1'b0;
      else if (tmo)  err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
`endif

endmodule
